// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receive path: FSM states and frame constants.
package uart_pkg;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_os_tick_gen.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, realignable via restart.
module uart_os_tick_gen #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 serial receiver: 2-flop synchroniser, 3-sample majority vote per bit,
// valid/ready byte output with frame-error pulse and sticky overrun flag.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned DIV = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned KW  = $clog2(OVERSAMPLE);
  localparam logic [KW-1:0] K_S0   = KW'(OVERSAMPLE / 2 - 1);
  localparam logic [KW-1:0] K_S1   = KW'(OVERSAMPLE / 2);
  localparam logic [KW-1:0] K_S2   = KW'(OVERSAMPLE / 2 + 1);
  localparam logic [KW-1:0] K_LAST = KW'(OVERSAMPLE - 1);

  rx_state_e            state;
  logic                 rx_meta, rxs;
  logic                 tick, restart;
  logic [KW-1:0]        k;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 s0, s1, maj, vote_pt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= IDLE_LEVEL;
      rxs     <= IDLE_LEVEL;
    end else begin
      rx_meta <= uart_rx;
      rxs     <= rx_meta;
    end
  end

  assign restart = (state == IDLE) && (rxs != IDLE_LEVEL);

  uart_os_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // Third sample is taken live at the vote point rather than stored.
  assign maj     = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign vote_pt = tick && (k == K_S2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      s0        <= IDLE_LEVEL;
      s1        <= IDLE_LEVEL;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (tick && (state == START || state == DATA || state == STOP)) begin
        k <= (k == K_LAST) ? '0 : k + 1'b1;
        if (k == K_S0) s0 <= rxs;
        if (k == K_S1) s1 <= rxs;
      end

      case (state)
        IDLE: begin
          if (rxs != IDLE_LEVEL) begin
            state <= START;
            k     <= '0;
          end
        end
        START: begin
          if (vote_pt && maj) state <= IDLE;
          else if (tick && k == K_LAST) state <= DATA;
        end
        DATA: begin
          if (vote_pt) shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (tick && k == K_LAST) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(DATA_BITS - 1)) state <= STOP;
          end
        end
        // Leave at the vote point so a back-to-back start edge is not missed;
        // the delivery below overrides the ready-driven clear above.
        STOP: begin
          if (vote_pt) begin
            if (maj) begin
              state <= IDLE;
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        BREAK: begin
          if (rxs == IDLE_LEVEL) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Bench for uart_rx_8n1 at 16 clocks per bit: vector table, randomised frames, corner sequences.
module tb_uart_rx_8n1;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun;

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [7:0]  got_q[$];
  int unsigned ferr_cnt = 0;
  int unsigned valid_cycles = 0;

  uart_rx_8n1 #(.CLK_HZ(1600), .BAUD(100), .OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) valid_cycles++;
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err) ferr_cnt++;
  end

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    int unsigned p2;        // twice the bit period in clocks
    int unsigned low_after; // clocks the line stays low after the frame
    int unsigned exp_n;
    logic [7:0]  exp_byte;
    int unsigned exp_ferr;
  } vec_t;

  vec_t vecs[$];

  task automatic step(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    ferr_cnt     = 0;
    valid_cycles = 0;
  endtask

  // Wire bit index at clock t is floor(2t/p2): 0 start, 1..8 data LSB first, 9 stop.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int unsigned p2);
    for (int unsigned t = 0; t < 5 * p2; t++) begin
      int unsigned idx;
      idx = (2 * t) / p2;
      if (idx == 0)      uart_rx = 1'b0;
      else if (idx <= 8) uart_rx = d[idx-1];
      else               uart_rx = stop;
      step(1);
    end
    uart_rx = 1'b1;
  endtask

  task automatic check_frame(input string name, input int unsigned n, input logic [7:0] b,
                             input int unsigned f);
    chk($sformatf("%s.nbytes", name), got_q.size(), n);
    if (n == 1 && got_q.size() == 1) chk($sformatf("%s.byte", name), got_q[0], b);
    chk($sformatf("%s.ferr", name), ferr_cnt, f);
    chk($sformatf("%s.vcycles", name), valid_cycles, n);
  endtask

  initial begin
    vecs.push_back('{8'hA5, 1'b1, 32, 0,  1, 8'hA5, 0});
    vecs.push_back('{8'h3C, 1'b0, 32, 0,  0, 8'h00, 1});
    vecs.push_back('{8'h81, 1'b1, 32, 0,  1, 8'h81, 0});
    vecs.push_back('{8'h55, 1'b1, 31, 0,  1, 8'h55, 0});
    vecs.push_back('{8'h55, 1'b1, 33, 0,  1, 8'h55, 0});
    vecs.push_back('{8'h00, 1'b0, 32, 40, 0, 8'h00, 1});
    vecs.push_back('{8'hFF, 1'b1, 32, 0,  1, 8'hFF, 0});

    rst = 1'b1;
    step(3);
    chk("reset.rx_valid", rx_valid, 0);
    chk("reset.rx_data", rx_data, 0);
    chk("reset.frame_err", frame_err, 0);
    chk("reset.overrun", overrun, 0);
    rst = 1'b0;
    step(5);

    foreach (vecs[i]) begin
      clear_mon();
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].p2);
      if (vecs[i].low_after > 0) begin
        uart_rx = 1'b0;
        step(vecs[i].low_after);
        uart_rx = 1'b1;
      end
      step(20);
      check_frame($sformatf("vec%0d", i), vecs[i].exp_n, vecs[i].exp_byte, vecs[i].exp_ferr);
      chk($sformatf("vec%0d.overrun", i), overrun, 0);
    end

    clear_mon();
    uart_rx = 1'b0;
    step(3);
    uart_rx = 1'b1;
    step(30);
    check_frame("glitch", 0, 8'h00, 0);
    chk("glitch.state_idle", int'(dut.state == IDLE), 1);

    for (int unsigned r = 0; r < 24; r++) begin
      logic [7:0]  d;
      logic        s;
      int unsigned p2;
      d  = 8'($urandom);
      s  = ($urandom_range(0, 3) != 0);
      p2 = $urandom_range(31, 33);
      clear_mon();
      send_frame(d, s, p2);
      step(20);
      check_frame($sformatf("rand%0d", r), s ? 1 : 0, d, s ? 0 : 1);
    end

    clear_mon();
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 32);
    send_frame(8'h22, 1'b1, 32);
    step(20);
    chk("ovr.rx_valid_held", rx_valid, 1);
    chk("ovr.rx_data_held", rx_data, 8'h11);
    chk("ovr.overrun_set", overrun, 1);
    rx_ready = 1'b1;
    step(2);
    chk("ovr.accepted_n", got_q.size(), 1);
    if (got_q.size() == 1) chk("ovr.accepted_byte", got_q[0], 8'h11);
    chk("ovr.rx_valid_clear", rx_valid, 0);
    chk("ovr.overrun_sticky", overrun, 1);
    step(10);

    // Abort 0xF0 in the middle of data bit 4, then a clean 0x0F.
    clear_mon();
    for (int unsigned t = 0; t < 88; t++) begin
      int unsigned idx;
      logic [7:0]  d;
      d   = 8'hF0;
      idx = t / 16;
      uart_rx = (idx == 0) ? 1'b0 : d[idx-1];
      step(1);
    end
    rst = 1'b1;
    uart_rx = 1'b1;
    step(3);
    chk("rstmid.rx_valid", rx_valid, 0);
    chk("rstmid.rx_data", rx_data, 0);
    chk("rstmid.frame_err", frame_err, 0);
    chk("rstmid.overrun", overrun, 0);
    rst = 1'b0;
    step(5);
    clear_mon();
    send_frame(8'h0F, 1'b1, 32);
    step(20);
    check_frame("rstmid.after", 1, 8'h0F, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
